button_event_ctrl: RTL and testbench

- Controller for the front-panel button inputs.
- Takes NUM_BTN already-synchronized button lines and runs one debounce state machine per button, clocked by a shared sample-tick prescaler.
- Converts each debounced press into an event.
- Arbitrates simultaneous events round-robin onto a single valid/ready event port consumed by the top-level control FSM.

---
 rtl/button_event_ctrl.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_button_event_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : button_event_ctrl
//  Description : Front-panel button controller. Per-button debounce FSMs run
//                on a shared sample tick; debounced presses become pending
//                events that are arbitrated round-robin onto one valid/ready
//                event port.
//  Options     : BTN_RELEASE_EVT_EN - also report debounced releases as
//                events (adds the evt_release output).
//  Revision    : 1.0 - initial release
// ============================================================================
module button_event_ctrl #(
    parameter int NUM_BTN      = 4,
    parameter int TICK_DIV     = 100000,
    parameter int STABLE_TICKS = 10,
    localparam int c_ID_W      = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_BTN-1:0] btn_sync,
    output logic [NUM_BTN-1:0] btn_level,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [c_ID_W-1:0]  evt_id,
    output logic               evt_drop
`ifdef BTN_RELEASE_EVT_EN
    ,
    output logic               evt_release
`endif
);

    localparam int c_CNT_W = $clog2(STABLE_TICKS + 1);
    localparam int c_DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_SUM_W = c_ID_W + 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(TICK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_DONE = c_CNT_W'(STABLE_TICKS);
    localparam logic [c_ID_W-1:0]  c_ID_LAST  = c_ID_W'(NUM_BTN - 1);

    typedef enum logic [1:0] {
        ST_LOW  = 2'd0,
        ST_RISE = 2'd1,
        ST_HIGH = 2'd2,
        ST_FALL = 2'd3
    } btn_state_t;

    // ------------------------------------------------------------------
    // Sample-tick prescaler
    // ------------------------------------------------------------------
    logic [c_DIV_W-1:0] r_presc;
    logic               w_tick;

    assign w_tick = (r_presc == c_DIV_LAST);

    // Free-running divider, one tick per TICK_DIV clocks
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + c_DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Per-button debounce FSMs
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] w_press;
    logic [NUM_BTN-1:0] w_release;

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
        btn_state_t         r_state;
        btn_state_t         w_state_nxt;
        logic [c_CNT_W-1:0] r_cnt;
        logic [c_CNT_W-1:0] w_cnt_nxt;
        logic [c_CNT_W-1:0] w_cnt_inc;
        logic               r_level;
        logic               w_level_nxt;
        logic               w_press_b;
        logic               w_release_b;

        assign w_cnt_inc     = r_cnt + c_CNT_W'(1);
        assign btn_level[gi] = r_level;
        assign w_press[gi]   = w_press_b;
        assign w_release[gi] = w_release_b;

        // Debounce state, counter and debounced level registers
        always_ff @(posedge clock) begin
            if (!reset_n) begin
                r_state <= ST_LOW;
                r_cnt   <= '0;
                r_level <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_level <= w_level_nxt;
            end
        end

        // Next state: a new level must survive STABLE_TICKS samples in a row
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_level_nxt = r_level;
            w_press_b   = 1'b0;
            w_release_b = 1'b0;
            if (w_tick) begin
                case (r_state)
                    ST_LOW: begin
                        if (btn_sync[gi]) begin
                            if (STABLE_TICKS == 1) begin
                                w_state_nxt = ST_HIGH;
                                w_cnt_nxt   = '0;
                                w_level_nxt = 1'b1;
                                w_press_b   = 1'b1;
                            end else begin
                                w_state_nxt = ST_RISE;
                                w_cnt_nxt   = c_CNT_W'(1);
                            end
                        end
                    end
                    ST_RISE: begin
                        if (!btn_sync[gi]) begin
                            w_state_nxt = ST_LOW;
                            w_cnt_nxt   = '0;
                        end else if (w_cnt_inc == c_CNT_DONE) begin
                            w_state_nxt = ST_HIGH;
                            w_cnt_nxt   = '0;
                            w_level_nxt = 1'b1;
                            w_press_b   = 1'b1;
                        end else begin
                            w_cnt_nxt   = w_cnt_inc;
                        end
                    end
                    ST_HIGH: begin
                        if (!btn_sync[gi]) begin
                            if (STABLE_TICKS == 1) begin
                                w_state_nxt = ST_LOW;
                                w_cnt_nxt   = '0;
                                w_level_nxt = 1'b0;
                                w_release_b = 1'b1;
                            end else begin
                                w_state_nxt = ST_FALL;
                                w_cnt_nxt   = c_CNT_W'(1);
                            end
                        end
                    end
                    ST_FALL: begin
                        if (btn_sync[gi]) begin
                            w_state_nxt = ST_HIGH;
                            w_cnt_nxt   = '0;
                        end else if (w_cnt_inc == c_CNT_DONE) begin
                            w_state_nxt = ST_LOW;
                            w_cnt_nxt   = '0;
                            w_level_nxt = 1'b0;
                            w_release_b = 1'b1;
                        end else begin
                            w_cnt_nxt   = w_cnt_inc;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_LOW;
                        w_cnt_nxt   = '0;
                        w_level_nxt = 1'b0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending vectors and round-robin arbitration
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] r_pend_press;
    logic [NUM_BTN-1:0] w_pend_press_nxt;
    logic [NUM_BTN-1:0] w_cand;
    logic [NUM_BTN-1:0] w_rot;
    logic [c_ID_W-1:0]  r_ptr;
    logic [c_ID_W-1:0]  w_ofs;
    logic [c_SUM_W-1:0] w_sum;
    logic [c_ID_W-1:0]  w_grant;
    logic               w_grant_press;
    logic               w_load;
    logic               w_drop;
    logic               r_evt_valid;
    logic [c_ID_W-1:0]  r_evt_id;
    logic               r_drop;

`ifdef BTN_RELEASE_EVT_EN
    logic [NUM_BTN-1:0] r_pend_rel;
    logic [NUM_BTN-1:0] w_pend_rel_nxt;
    logic               r_evt_release;

    assign w_cand      = r_pend_press | r_pend_rel;
    assign evt_release = r_evt_release;
`else
    logic w_unused_release;

    // Releases only move btn_level in this build
    assign w_unused_release = |w_release;
    assign w_cand           = r_pend_press;
`endif

    // Rotate so bit 0 is the button at the pointer; search then starts at 0
    assign w_rot         = NUM_BTN'({w_cand, w_cand} >> r_ptr);
    assign w_sum         = {1'b0, r_ptr} + {1'b0, w_ofs};
    assign w_grant       = (w_sum >= c_SUM_W'(NUM_BTN)) ?
                           c_ID_W'(w_sum - c_SUM_W'(NUM_BTN)) : c_ID_W'(w_sum);
    assign w_grant_press = r_pend_press[w_grant];
    assign w_load        = (!r_evt_valid || evt_ready) && (|w_cand);

    // Offset of the first candidate at or after the pointer
    always_comb begin
        w_ofs = '0;
        for (int k = NUM_BTN - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_ofs = c_ID_W'(k);
            end
        end
    end

    // Pending update: grant clears first so a same-cycle strobe re-sets it
    always_comb begin
        w_pend_press_nxt = r_pend_press;
        w_drop           = 1'b0;
`ifdef BTN_RELEASE_EVT_EN
        w_pend_rel_nxt   = r_pend_rel;
`endif
        for (int i = 0; i < NUM_BTN; i++) begin
            if (w_load && (w_grant == c_ID_W'(i)) && w_grant_press) begin
                w_pend_press_nxt[i] = 1'b0;
            end
            if (w_press[i]) begin
                if (w_pend_press_nxt[i]) begin
                    w_drop = 1'b1;
                end
                w_pend_press_nxt[i] = 1'b1;
            end
`ifdef BTN_RELEASE_EVT_EN
            if (w_load && (w_grant == c_ID_W'(i)) && !w_grant_press) begin
                w_pend_rel_nxt[i] = 1'b0;
            end
            if (w_release[i]) begin
                if (w_pend_rel_nxt[i]) begin
                    w_drop = 1'b1;
                end
                w_pend_rel_nxt[i] = 1'b1;
            end
`endif
        end
    end

    // Event register, pointer, pending bits and drop pulse
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_pend_press  <= '0;
            r_ptr         <= '0;
            r_evt_valid   <= 1'b0;
            r_evt_id      <= '0;
            r_drop        <= 1'b0;
`ifdef BTN_RELEASE_EVT_EN
            r_pend_rel    <= '0;
            r_evt_release <= 1'b0;
`endif
        end else begin
            r_pend_press <= w_pend_press_nxt;
            r_drop       <= w_drop;
`ifdef BTN_RELEASE_EVT_EN
            r_pend_rel   <= w_pend_rel_nxt;
`endif
            if (w_load) begin
                r_evt_valid   <= 1'b1;
                r_evt_id      <= w_grant;
                r_ptr         <= (w_grant == c_ID_LAST) ? '0 : w_grant + c_ID_W'(1);
`ifdef BTN_RELEASE_EVT_EN
                r_evt_release <= !w_grant_press;
`endif
            end else if (evt_ready) begin
                r_evt_valid <= 1'b0;
            end
        end
    end

    assign evt_valid = r_evt_valid;
    assign evt_id    = r_evt_id;
    assign evt_drop  = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_button_event_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_event_ctrl
//  Description : Directed self-checking bench for button_event_ctrl with
//                NUM_BTN=4, TICK_DIV=4, STABLE_TICKS=3.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_event_ctrl;

    localparam int c_TICK_DIV = 4;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] btn_sync;
    logic [3:0] btn_level;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_id;
    logic       evt_drop;
`ifdef BTN_RELEASE_EVT_EN
    logic       evt_release;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clock = ~clock;

    button_event_ctrl #(
        .NUM_BTN      (4),
        .TICK_DIV     (c_TICK_DIV),
        .STABLE_TICKS (3)
    ) u_dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .btn_sync  (btn_sync),
        .btn_level (btn_level),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_drop  (evt_drop)
`ifdef BTN_RELEASE_EVT_EN
        ,
        .evt_release (evt_release)
`endif
    );

    // One clock, sampled 1 time unit after the rising edge
    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Advance to just after the next tick edge (cycles since reset % 4 == 0)
    task automatic next_tick();
        step();
        while (cyc % c_TICK_DIV != 0) step();
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) next_tick();
    endtask

    // Run n ticks, counting drop samples and samples with any level/event
    task automatic run_ticks(input int n, inout int drops, inout int busy);
        for (int t = 0; t < n; t++) begin
            step();
            if (evt_drop) drops++;
            if (btn_level != 4'h0 || evt_valid) busy++;
            while (cyc % c_TICK_DIV != 0) begin
                step();
                if (evt_drop) drops++;
                if (btn_level != 4'h0 || evt_valid) busy++;
            end
        end
    endtask

    // Record accepted events (valid & ready before the edge) for ncyc cycles
    task automatic collect(input int ncyc, inout int n, inout logic [7:0] seq);
        for (int i = 0; i < ncyc; i++) begin
            if (evt_valid && evt_ready) begin
                n++;
                seq = {seq[5:0], evt_id};
            end
            step();
        end
    endtask

    task automatic test_reset();
        int bad;
        bad = 0;
        reset_n   = 1'b0;
        btn_sync  = 4'hF;
        evt_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (btn_level !== 4'h0 || evt_valid !== 1'b0 || evt_drop !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL reset_hold: %0d bad samples, want 0", bad);
        end
        checks++;
        if (evt_id !== 2'd0) begin
            errors++; $display("FAIL reset_id: got %0d want 0", evt_id);
        end
        reset_n = 1'b1;
        cyc = 0;
        bad = 0;
        for (int i = 0; i < 11; i++) begin
            step();
            if (btn_level !== 4'h0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL reset_early_level: %0d early samples, want 0", bad);
        end
        step();
        checks++;
        if (btn_level !== 4'hF || evt_valid !== 1'b0) begin
            errors++; $display("FAIL reset_level12: level %h valid %0d want F 0", btn_level, evt_valid);
        end
        step();
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin
            errors++; $display("FAIL reset_first_evt: valid %0d id %0d want 1 0", evt_valid, evt_id);
        end
        begin
            int n; logic [7:0] seq;
            n = 0; seq = 8'h00;
            btn_sync  = 4'h0;
            evt_ready = 1'b1;
            collect(8, n, seq);
            checks++;
            if (n !== 4 || seq !== 8'h1B) begin
                errors++; $display("FAIL reset_drain: n %0d seq %h want 4 1b", n, seq);
            end
        end
        wait_ticks(2);
        evt_ready = 1'b0;
        checks++;
        if (btn_level !== 4'h0 || evt_valid !== 1'b0) begin
            errors++; $display("FAIL reset_release: level %h valid %0d want 0 0", btn_level, evt_valid);
        end
    endtask

    task automatic test_bounce();
        int drops, busy;
        drops = 0; busy = 0;
        next_tick();
        btn_sync = 4'b0010; run_ticks(2, drops, busy);
        btn_sync = 4'b0000; run_ticks(1, drops, busy);
        btn_sync = 4'b0010; run_ticks(2, drops, busy);
        btn_sync = 4'b0000; run_ticks(4, drops, busy);
        checks++;
        if (busy !== 0) begin
            errors++; $display("FAIL bounce: %0d samples with level/event, want 0", busy);
        end
    endtask

    task automatic test_simultaneous(input logic [1:0] first, input logic [7:0] exp_seq);
        int n, drops, busy;
        logic [7:0] seq;
        n = 0; seq = 8'h00; drops = 0; busy = 0;
        next_tick();
        btn_sync  = 4'b1011;
        evt_ready = 1'b1;
        for (int i = 0; i < 12; i++) step();
        checks++;
        if (btn_level !== 4'b1011 || evt_valid !== 1'b0) begin
            errors++; $display("FAIL simul_level: level %b valid %0d want 1011 0", btn_level, evt_valid);
        end
        step();
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== first) begin
            errors++; $display("FAIL simul_first: valid %0d id %0d want 1 %0d", evt_valid, evt_id, first);
        end
        collect(6, n, seq);
        checks++;
        if (n !== 3 || seq !== exp_seq) begin
            errors++; $display("FAIL simul_order: n %0d seq %h want 3 %h", n, seq, exp_seq);
        end
        btn_sync = 4'h0;
        run_ticks(4, drops, busy);
        checks++;
        if (btn_level !== 4'h0 || evt_valid !== 1'b0 || drops !== 0) begin
            errors++; $display("FAIL simul_release: level %h valid %0d drops %0d want 0 0 0", btn_level, evt_valid, drops);
        end
        evt_ready = 1'b0;
    endtask

    task automatic test_clean_press();
        int bad, drops, busy;
        bad = 0; drops = 0; busy = 0;
        next_tick();
        btn_sync  = 4'b0100;
        evt_ready = 1'b0;
        for (int i = 0; i < 11; i++) begin
            step();
            if (btn_level !== 4'h0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL press_early: %0d early samples, want 0", bad);
        end
        step();
        checks++;
        if (btn_level !== 4'b0100 || evt_valid !== 1'b0) begin
            errors++; $display("FAIL press_level: level %b valid %0d want 0100 0", btn_level, evt_valid);
        end
        step();
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin
            errors++; $display("FAIL press_evt: valid %0d id %0d want 1 2", evt_valid, evt_id);
        end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (evt_valid !== 1'b1 || evt_id !== 2'd2) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL press_hold: %0d unstable samples, want 0", bad);
        end
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++; $display("FAIL press_accept: valid %0d want 0", evt_valid);
        end
        btn_sync = 4'h0;
        run_ticks(4, drops, busy);
        checks++;
        if (btn_level !== 4'h0 || evt_valid !== 1'b0) begin
            errors++; $display("FAIL press_release: level %h valid %0d want 0 0", btn_level, evt_valid);
        end
    endtask

    task automatic test_drop();
        int n, drops, busy;
        logic [7:0] seq;
        n = 0; seq = 8'h00; drops = 0; busy = 0;
        next_tick();
        evt_ready = 1'b0;
        for (int p = 0; p < 2; p++) begin
            btn_sync = 4'b0001; run_ticks(3, drops, busy);
            btn_sync = 4'b0000; run_ticks(3, drops, busy);
        end
        btn_sync = 4'b0001; run_ticks(3, drops, busy);
        checks++;
        if (evt_drop !== 1'b1) begin
            errors++; $display("FAIL drop_pulse: got %0d want 1", evt_drop);
        end
        checks++;
        if (drops !== 1) begin
            errors++; $display("FAIL drop_count: got %0d drop samples want 1", drops);
        end
        btn_sync  = 4'b0000;
        evt_ready = 1'b1;
        collect(1, n, seq);
        checks++;
        if (evt_drop !== 1'b0) begin
            errors++; $display("FAIL drop_width: got %0d want 0", evt_drop);
        end
        collect(20, n, seq);
        checks++;
        if (n !== 2 || seq !== 8'h00) begin
            errors++; $display("FAIL drop_events: n %0d seq %h want 2 00", n, seq);
        end
        evt_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int bad, n;
        logic [7:0] seq;
        bad = 0; n = 0; seq = 8'h00;
        next_tick();
        btn_sync  = 4'b0001;
        evt_ready = 1'b0;
        wait_ticks(3);
        step();
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin
            errors++; $display("FAIL mid_setup: valid %0d id %0d want 1 0", evt_valid, evt_id);
        end
        next_tick();
        btn_sync = 4'b1001;
        wait_ticks(2);
        reset_n = 1'b0;
        step();
        checks++;
        if (evt_valid !== 1'b0 || btn_level !== 4'h0) begin
            errors++; $display("FAIL mid_reset: valid %0d level %h want 0 0", evt_valid, btn_level);
        end
        reset_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < 11; i++) begin
            step();
            if (btn_level !== 4'h0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL mid_early: %0d early samples, want 0", bad);
        end
        step();
        checks++;
        if (btn_level !== 4'b1001) begin
            errors++; $display("FAIL mid_level: got %b want 1001", btn_level);
        end
        step();
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin
            errors++; $display("FAIL mid_evt: valid %0d id %0d want 1 0", evt_valid, evt_id);
        end
        evt_ready = 1'b1;
        btn_sync  = 4'h0;
        collect(10, n, seq);
        checks++;
        if (n !== 2 || seq !== 8'h03) begin
            errors++; $display("FAIL mid_drain: n %0d seq %h want 2 03", n, seq);
        end
        wait_ticks(4);
        evt_ready = 1'b0;
        checks++;
        if (btn_level !== 4'h0 || evt_valid !== 1'b0) begin
            errors++; $display("FAIL mid_release: level %h valid %0d want 0 0", btn_level, evt_valid);
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_simultaneous(2'd0, 8'h07);
        test_clean_press();
        test_simultaneous(2'd3, 8'h31);
        test_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
